// File: rtl/word_uart_tx.sv
// Purpose: sends a 16-bit word as two back-to-back 8N1 UART bytes, low byte first.
// Latency: start bit on the edge that accepts the word; tx_done pulses 20*CLKS_PER_BIT cycles later.
// Backpressure: no queueing. A request that arrives while busy is dropped and sets the sticky overrun flag.
//
// Ports:
//   clk           system clock, rising-edge active
//   rst           synchronous active-high reset; aborts any frame in flight
//   data_in       word to send, captured only when it is accepted
//   data_in_valid one-cycle send request
//   tx            serial line, idle high
//   tx_done       one-cycle pulse after the second stop bit ends
//   busy          high from acceptance until the word completes
//   overrun       sticky; set by a request that arrives while busy
module word_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        data_in_valid,
  output logic        tx,
  output logic        tx_done,
  output logic        busy,
  output logic        overrun
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic          byte_q;
  logic [15:0]   word_q;
  logic          done_q;
  logic          ovr_q;

  logic accept;
  logic baud_wrap;

  // A word is accepted only while idle. This includes the tx_done cycle,
  // which lets consecutive words run with no extra gap.
  assign accept    = data_in_valid && (state_q == IDLE);
  assign baud_wrap = (baud_q == BAUD_LAST);

  // State register, together with the counters and the captured word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= 1'b0;
      word_q  <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // The word is complete when byte1's stop bit ends.
      done_q  <= (state_q == STOP) && baud_wrap && byte_q;
      if (data_in_valid && (state_q != IDLE)) begin
        ovr_q <= 1'b1;
      end
      if (accept) begin
        word_q <= data_in;
        baud_q <= '0;
        bit_q  <= '0;
        byte_q <= 1'b0;
      end else if (state_q != IDLE) begin
        baud_q <= baud_wrap ? '0 : baud_q + CW'(1);
        if (baud_wrap && (state_q == DATA)) begin
          bit_q <= bit_q + 3'd1;  // wraps from 7 back to 0 as DATA ends
        end
        if (baud_wrap && (state_q == STOP)) begin
          byte_q <= ~byte_q;      // byte1 goes back to 0 on entering IDLE
        end
      end
    end
  end

  // Next-state logic. Every bit period ends only when the baud counter wraps.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = START;
      START:   if (baud_wrap) state_d = DATA;
      DATA:    if (baud_wrap && (bit_q == 3'd7)) state_d = STOP;
      STOP:    if (baud_wrap) state_d = byte_q ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    tx   = 1'b1;
    busy = (state_q != IDLE);
    case (state_q)
      IDLE:    tx = 1'b1;
      START:   tx = 1'b0;
      DATA:    tx = word_q[{byte_q, bit_q}];
      STOP:    tx = 1'b1;
      default: tx = 1'b1;
    endcase
  end

  assign tx_done = done_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_word_uart_tx.sv
module tb_word_uart_tx;

  localparam int C  = 4;
  localparam int C2 = 868;

  logic        clk;
  logic        rst;
  logic [15:0] data_in;
  logic        data_in_valid;
  logic        tx;
  logic        tx_done;
  logic        busy;
  logic        overrun;

  logic [15:0] data_in_b;
  logic        data_in_valid_b;
  logic        tx_b;
  logic        tx_done_b;
  logic        busy_b;
  logic        overrun_b;

  int vectors;
  int miscompares;
  logic ovr_model;

  word_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .tx            (tx),
    .tx_done       (tx_done),
    .busy          (busy),
    .overrun       (overrun)
  );

  word_uart_tx #(.CLKS_PER_BIT(C2)) dut_big (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in_b),
    .data_in_valid (data_in_valid_b),
    .tx            (tx_b),
    .tx_done       (tx_done_b),
    .busy          (busy_b),
    .overrun       (overrun_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line bits in time order, index 0 first: start, 8 data bits LSB first,
  // stop, and then the same for the high byte.
  function automatic logic [19:0] frame_bits(input logic [15:0] w);
    return {1'b1, w[15:8], 1'b0, 1'b1, w[7:0], 1'b0};
  endfunction

  // Sends one word and checks every cycle of it against the expected line pattern.
  //   chained    : the previous call already raised valid for this word
  //   chain_next : raise valid for w_next during the tx_done cycle
  //   poke_at    : cycle at which a competing request (16'hBEEF) is driven
  //   abort_at   : cycle at which rst is raised
  task automatic xmit(input logic [15:0] w, input logic [19:0] pat, input bit scr,
                      input int poke_at, input int abort_at, input bit chained,
                      input bit chain_next, input logic [15:0] w_next);
    int nc;
    nc = 20 * C;
    if (!chained) begin
      @(negedge clk);
      data_in = w;
      data_in_valid = 1'b1;
    end
    for (int k = 0; k <= nc; k++) begin
      @(negedge clk);
      data_in_valid = 1'b0;
      if (scr) data_in = 16'($urandom);
      if (poke_at >= 0 && k == poke_at + 1) ovr_model = 1'b1;
      if (abort_at >= 0 && k == abort_at + 1) begin
        ovr_model = 1'b0;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(tx_done), 32'd0);
        check("abort_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        for (int j = 0; j < 2 * C; j++) begin
          @(negedge clk);
          check("post_abort_done", 32'(tx_done), 32'd0);
          check("post_abort_tx", 32'(tx), 32'd1);
        end
        return;
      end
      if (k < nc) begin
        check("line_bit", 32'(tx), 32'(pat[k / C]));
        check("busy_mid", 32'(busy), 32'd1);
        check("done_mid", 32'(tx_done), 32'd0);
      end else begin
        check("done_pulse", 32'(tx_done), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
        check("tx_end", 32'(tx), 32'd1);
      end
      check("overrun", 32'(overrun), 32'(ovr_model));
      if (k == poke_at) begin
        data_in = 16'hBEEF;
        data_in_valid = 1'b1;
      end
      if (k == abort_at) rst = 1'b1;
      if (k == nc && chain_next) begin
        data_in = w_next;
        data_in_valid = 1'b1;
      end
    end
    if (!chain_next) begin
      @(negedge clk);
      check("done_single", 32'(tx_done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_tx", 32'(tx), 32'd1);
    end
  endtask

  initial begin
    logic [15:0] cur;
    logic [15:0] nxt;
    logic [19:0] f0;
    bit chn;
    bit nchn;
    vectors = 0;
    miscompares = 0;
    ovr_model = 1'b0;
    rst = 1'b1;
    data_in = '0;
    data_in_valid = 1'b0;
    data_in_b = '0;
    data_in_valid_b = 1'b0;

    // Reset, with a request in the same cycle that must lose to reset.
    @(negedge clk);
    data_in = 16'h5555;
    data_in_valid = 1'b1;
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_big_tx", 32'(tx_b), 32'd1);
    check("rst_big_busy", 32'(busy_b), 32'd0);
    data_in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_prio_busy", 32'(busy), 32'd0);

    // Directed single word with a literal expected line pattern.
    xmit(16'hA55A, 20'b1101_0010_1010_1011_0100, 1'b0, -1, -1, 1'b0, 1'b0, 16'h0000);

    // Back-to-back: the next word is requested in the tx_done cycle.
    xmit(16'hFFFF, frame_bits(16'hFFFF), 1'b0, -1, -1, 1'b0, 1'b1, 16'h0001);
    xmit(16'h0001, frame_bits(16'h0001), 1'b0, -1, -1, 1'b1, 1'b0, 16'h0000);

    // data_in changes every cycle after acceptance.
    xmit(16'hC3C3, frame_bits(16'hC3C3), 1'b1, -1, -1, 1'b0, 1'b0, 16'h0000);

    // Random words, some chained, some with a noisy data_in.
    cur = 16'($urandom);
    chn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      nxt = 16'($urandom);
      nchn = (i < 5) && ($urandom_range(0, 1) == 1);
      xmit(cur, frame_bits(cur), $urandom_range(0, 1) == 1, -1, -1, chn, nchn, nxt);
      cur = nxt;
      chn = nchn;
    end

    // Reset in the middle of a frame, then a clean word.
    cur = 16'($urandom);
    xmit(cur, frame_bits(cur), 1'b0, -1, 30, 1'b0, 1'b0, 16'h0000);
    xmit(16'h00FF, frame_bits(16'h00FF), 1'b0, -1, -1, 1'b0, 1'b0, 16'h0000);

    // Overrun: a second request 10 cycles in is dropped, and the flag is sticky.
    xmit(16'h1234, frame_bits(16'h1234), 1'b0, 10, -1, 1'b0, 1'b0, 16'h0000);
    cur = 16'($urandom);
    xmit(cur, frame_bits(cur), 1'b0, -1, -1, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    ovr_model = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'(ovr_model));

    // Full-rate baud: CLKS_PER_BIT = 868, all-zero word.
    f0 = frame_bits(16'h0000);
    @(negedge clk);
    data_in_b = 16'h0000;
    data_in_valid_b = 1'b1;
    for (int k = 0; k <= 20 * C2; k++) begin
      @(negedge clk);
      data_in_valid_b = 1'b0;
      if (k < 20 * C2) begin
        check("big_bit", 32'(tx_b), 32'(f0[k / C2]));
        check("big_done_mid", 32'(tx_done_b), 32'd0);
      end else begin
        check("big_done", 32'(tx_done_b), 32'd1);
        check("big_busy_end", 32'(busy_b), 32'd0);
      end
    end
    @(negedge clk);
    check("big_done_single", 32'(tx_done_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
